// File: rtl/adc_channel_scanner_if.sv
// ---------------------------------------------------------------------------
// adc_channel_scanner_if
// Bundles the scanner's link to the LTC2308 interface stage (channel select
// out, frame strobe and result in) with its published-average bus.
//   adc_convst  : copy of ADC_CONVST, high for one clock at each frame start
//   adc_result  : 12-bit result, stable across a frame
//   chan        : 3-bit channel select towards the ADC interface
//   avg_data    : latest completed average
//   avg_chan    : channel that avg_data belongs to
//   avg_valid   : one-cycle pulse marking a new avg_data/avg_chan
// master = scanner side, slave = ADC interface / consumer side.
// ---------------------------------------------------------------------------
interface adc_channel_scanner_if;
    logic        adc_convst;
    logic [11:0] adc_result;
    logic [2:0]  chan;
    logic [11:0] avg_data;
    logic [2:0]  avg_chan;
    logic        avg_valid;

    modport master (
        input  adc_convst,
        input  adc_result,
        output chan,
        output avg_data,
        output avg_chan,
        output avg_valid
    );

    modport slave (
        output adc_convst,
        output adc_result,
        input  chan,
        input  avg_data,
        input  avg_chan,
        input  avg_valid
    );
endinterface

// File: rtl/adc_channel_scanner.sv
// ---------------------------------------------------------------------------
// adc_channel_scanner
// Scans NUM_CHAN ADC channels round-robin. After every channel switch the
// first completed frame still carries the old channel's conversion and is
// dropped; the next 2^AVG_LOG2 samples are summed and the truncated mean is
// published on the bus and stored in a per-channel table.
// Ports:
//   clk      : system clock (posedge)
//   reset_n  : asynchronous active-low reset
//   enable   : scan enable, level
//   bus      : adc_channel_scanner_if.master (ADC link + average output)
//   rd_chan  : table read address
//   rd_data  : stored average for rd_chan, 0 for rd_chan >= NUM_CHAN
//   seen     : bit i set once channel i has produced an average
// ---------------------------------------------------------------------------
module adc_channel_scanner #(
    parameter int NUM_CHAN = 2,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    adc_channel_scanner_if.master bus,
    input  logic [2:0]            rd_chan,
    output logic [11:0]           rd_data,
    output logic [7:0]            seen
);

    localparam int DATA_W = 12;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]       LAST_CHAN = 3'(NUM_CHAN - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, EMIT} state_t;

    state_t                  state_q, state_d;
    logic                    convst_d;
    logic                    strobe;
    logic                    acc_clr, acc_add, emit;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2:0]              chan_q;
    logic [DATA_W-1:0]       avg_data_q;
    logic [2:0]              avg_chan_q;
    logic                    avg_valid_q;
    logic [7:0]              seen_q;
    logic [DATA_W-1:0]       table_q [NUM_CHAN];

    // Truncating mean of the accumulated samples.
    function automatic logic [DATA_W-1:0] trunc_avg(input logic [ACC_W-1:0] a);
        return DATA_W'(a >> AVG_LOG2);
    endfunction

    // Rising edge of CONVST marks a completed frame; a held-high CONVST
    // therefore counts once.
    assign strobe = bus.adc_convst & ~convst_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        acc_add = 1'b0;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = SETTLE;
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    // Stale sample from the previous channel: dropped.
                    acc_clr = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    acc_add = 1'b1;
                    if (cnt_q == LAST_CNT) state_d = EMIT;
                end
            end
            EMIT: begin
                // Always completes, even if enable has dropped.
                emit    = 1'b1;
                state_d = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_d    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            chan_q      <= '0;
            avg_data_q  <= '0;
            avg_chan_q  <= '0;
            avg_valid_q <= 1'b0;
            seen_q      <= '0;
            for (int i = 0; i < NUM_CHAN; i++) table_q[i] <= '0;
        end else begin
            convst_d    <= bus.adc_convst;
            avg_valid_q <= emit;
            if (acc_clr) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (acc_add) begin
                acc_q <= acc_q + ACC_W'(bus.adc_result);
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (emit) begin
                avg_data_q     <= trunc_avg(acc_q);
                avg_chan_q     <= chan_q;
                seen_q[chan_q] <= 1'b1;
                chan_q         <= (chan_q == LAST_CHAN) ? 3'd0 : chan_q + 3'd1;
                for (int i = 0; i < NUM_CHAN; i++) begin
                    if (chan_q == 3'(i)) table_q[i] <= trunc_avg(acc_q);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (rd_chan == 3'(i)) rd_data = table_q[i];
        end
    end

    assign bus.chan      = chan_q;
    assign bus.avg_data  = avg_data_q;
    assign bus.avg_chan  = avg_chan_q;
    assign bus.avg_valid = avg_valid_q;
    assign seen          = seen_q;

endmodule

// File: tb/tb_adc_channel_scanner.sv
// ---------------------------------------------------------------------------
// tb_adc_channel_scanner
// Two scanner instances: A with default parameters (2 channels, 4-sample
// averages) and B with NUM_CHAN=3, AVG_LOG2=0. Frames are 16 clocks long
// with CONVST high at the start. Expected averages are queued when the last
// sample of a group is driven and checked when avg_valid pulses.
// ---------------------------------------------------------------------------
module tb_adc_channel_scanner;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  ch;
        logic [2:0]  nxt;
    } exp_t;

    logic        clk;
    logic        reset_n, reset_n_b;
    logic        enable, enable_b;
    logic [2:0]  rd_chan, rd_chan_b;
    logic [11:0] rd_data, rd_data_b;
    logic [7:0]  seen, seen_b;

    int   checks = 0;
    int   errors = 0;
    int   vcnt_a = 0;
    int   vcnt_b = 0;
    int   vsnap;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    adc_channel_scanner_if ifa ();
    adc_channel_scanner_if ifb ();

    adc_channel_scanner #(.NUM_CHAN(2), .AVG_LOG2(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (ifa),
        .rd_chan (rd_chan),
        .rd_data (rd_data),
        .seen    (seen)
    );

    adc_channel_scanner #(.NUM_CHAN(3), .AVG_LOG2(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n_b),
        .enable  (enable_b),
        .bus     (ifb),
        .rd_chan (rd_chan_b),
        .rd_data (rd_data_b),
        .seen    (seen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int data, input int ch, input int nxt);
        exp_t e;
        e.data = 12'(data);
        e.ch   = 3'(ch);
        e.nxt  = 3'(nxt);
        return e;
    endfunction

    // One 16-clock frame on A; CONVST held high for 'hi' clocks.
    task automatic frame_a(input int v, input int hi);
        @(posedge clk);
        #1;
        ifa.adc_result = 12'(v);
        ifa.adc_convst = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        ifa.adc_convst = 1'b0;
        repeat (15 - hi) @(posedge clk);
    endtask

    task automatic frame_b(input int v);
        @(posedge clk);
        #1;
        ifb.adc_result = 12'(v);
        ifb.adc_convst = 1'b1;
        @(posedge clk);
        #1;
        ifb.adc_convst = 1'b0;
        repeat (14) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (ifa.avg_valid) begin
            vcnt_a++;
            chk("a_valid_expected", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                chk("a_avg_data", 32'(ifa.avg_data), 32'(e_a.data));
                chk("a_avg_chan", 32'(ifa.avg_chan), 32'(e_a.ch));
                chk("a_chan_next", 32'(ifa.chan), 32'(e_a.nxt));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.avg_valid) begin
            vcnt_b++;
            chk("b_valid_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                chk("b_avg_data", 32'(ifb.avg_data), 32'(e_b.data));
                chk("b_avg_chan", 32'(ifb.avg_chan), 32'(e_b.ch));
                chk("b_chan_next", 32'(ifb.chan), 32'(e_b.nxt));
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        reset_n_b      = 1'b0;
        enable         = 1'b0;
        enable_b       = 1'b0;
        rd_chan        = 3'd0;
        rd_chan_b      = 3'd0;
        ifa.adc_convst = 1'b0;
        ifa.adc_result = 12'd0;
        ifb.adc_convst = 1'b0;
        ifb.adc_result = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        reset_n_b = 1'b1;
        @(negedge clk);
        chk("rst_chan", 32'(ifa.chan), 0);
        chk("rst_avg_data", 32'(ifa.avg_data), 0);
        chk("rst_avg_chan", 32'(ifa.avg_chan), 0);
        chk("rst_avg_valid", 32'(ifa.avg_valid), 0);
        chk("rst_seen", 32'(seen), 0);
        chk("rst_rd_data", 32'(rd_data), 0);

        // Channel 0: stale 999, then 100/200/300/403 -> 1003/4 = 250.
        enable = 1'b1;
        frame_a(999, 1);
        frame_a(100, 1);
        frame_a(200, 1);
        frame_a(300, 1);
        q_a.push_back(mk((100 + 200 + 300 + 403) / 4, 0, 1));
        frame_a(403, 1);
        @(negedge clk);
        chk("a_vcnt_first", vcnt_a, 1);
        chk("a_seen_01", 32'(seen), 32'h01);
        rd_chan = 3'd0;
        #1;
        chk("a_table0_250", 32'(rd_data), 250);

        // Channel 1: stale 4000, then full-scale samples; chan wraps to 0.
        frame_a(4000, 1);
        repeat (3) frame_a(4095, 1);
        q_a.push_back(mk(4095, 1, 0));
        frame_a(4095, 1);
        @(negedge clk);
        chk("a_seen_03", 32'(seen), 32'h03);
        rd_chan = 3'd1;
        #1;
        chk("a_table1_4095", 32'(rd_data), 4095);

        // Channel 0 again: first strobe (7) must be discarded.
        frame_a(7, 1);
        frame_a(10, 1);
        frame_a(20, 1);
        frame_a(30, 1);
        q_a.push_back(mk(25, 0, 1));
        frame_a(40, 1);

        // Channel 1: drop enable after 3 accumulated samples.
        frame_a(50, 1);
        frame_a(60, 1);
        frame_a(70, 1);
        frame_a(80, 1);
        vsnap = vcnt_a;
        #1;
        enable = 1'b0;
        frame_a(4000, 1);
        frame_a(4000, 1);
        @(negedge clk);
        chk("a_disable_no_valid", vcnt_a, vsnap);
        chk("a_disable_chan", 32'(ifa.chan), 1);
        rd_chan = 3'd0;
        #1;
        chk("a_disable_table0", 32'(rd_data), 25);
        // Re-enable: one discard then four fresh samples, 36/4 = 9.
        enable = 1'b1;
        frame_a(1000, 1);
        frame_a(8, 1);
        frame_a(8, 1);
        frame_a(8, 1);
        q_a.push_back(mk(9, 1, 0));
        frame_a(12, 1);

        // Channel 0 with CONVST held 3 clocks: each counts once, 400/4 = 100.
        frame_a(5, 3);
        frame_a(40, 3);
        frame_a(80, 3);
        frame_a(120, 3);
        q_a.push_back(mk(100, 0, 1));
        frame_a(160, 3);
        rd_chan = 3'd5;
        #1;
        chk("a_rd_out_of_range", 32'(rd_data), 0);

        // Channel 1: reset asynchronously after two accumulated samples.
        frame_a(1, 1);
        frame_a(3, 1);
        frame_a(4, 1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        rd_chan = 3'd0;
        #1;
        chk("arst_chan", 32'(ifa.chan), 0);
        chk("arst_seen", 32'(seen), 0);
        chk("arst_avg_data", 32'(ifa.avg_data), 0);
        chk("arst_avg_chan", 32'(ifa.avg_chan), 0);
        chk("arst_rd_data", 32'(rd_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        vsnap   = vcnt_a;
        frame_a(500, 1);
        frame_a(4, 1);
        frame_a(8, 1);
        @(negedge clk);
        chk("arst_no_early_valid", vcnt_a, vsnap);
        frame_a(12, 1);
        q_a.push_back(mk(10, 0, 1));
        frame_a(16, 1);
        @(negedge clk);
        chk("arst_valid_after_full", vcnt_a, vsnap + 1);

        // Instance B: one sample per average, discard between each.
        enable_b = 1'b1;
        frame_b(11);
        q_b.push_back(mk(21, 0, 1));
        frame_b(21);
        frame_b(12);
        q_b.push_back(mk(22, 1, 2));
        frame_b(22);
        frame_b(13);
        q_b.push_back(mk(23, 2, 0));
        frame_b(23);
        frame_b(14);
        q_b.push_back(mk(24, 0, 1));
        frame_b(24);
        @(negedge clk);
        chk("b_vcnt", vcnt_b, 4);
        chk("b_seen_07", 32'(seen_b), 32'h07);
        rd_chan_b = 3'd2;
        #1;
        chk("b_table2", 32'(rd_data_b), 23);
        rd_chan_b = 3'd3;
        #1;
        chk("b_rd_out_of_range", 32'(rd_data_b), 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
